fpu_sched: RTL and testbench

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_sched.sv | 167 ++++++++++++++++
 tb/tb_fpu_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sched.sv
// fpu_sched: arbitrates two requesters onto one shared FP adder/divider pair.
// Only one operation is in flight at a time. Grant is round-robin, and a lone
// requester always wins. The module captures the operands, starts the shared
// units, waits a fixed latency, latches the selected unit's result and pulses
// done to the owner.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/req1            requests, held by the requester until its done
//   op0/op1              0 = add, 1 = divide
//   a0,b0,a1,b1          IEEE-754 single operands
//   gnt0/gnt1            one-cycle pulse: operands captured
//   done0/done1          one-cycle pulse: res valid for that requester
//   res                  result of the last completed operation
//   busy                 high whenever not idle
//   dp_a, dp_b, dp_sel   registered operands / unit select (0 add, 1 div)
//   dp_start             one-cycle start pulse to the shared units
//   sum_res, div_res     results returned by the shared units
module fpu_sched #(
  parameter int unsigned DIV_LAT = 24,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic        busy,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_sel,
  output logic        dp_start,
  input  logic [31:0] sum_res,
  input  logic [31:0] div_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);
  localparam logic [7:0] ADD_CNT = 8'(ADD_LAT);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        start_q, start_d;
  logic        sel_q, sel_d;
  logic [31:0] dpa_q, dpa_d;
  logic [31:0] dpb_q, dpb_d;
  logic [31:0] res_q, res_d;
  logic        win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= 1'b0;
      dpa_q   <= '0;
      dpb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      dpa_q   <= dpa_d;
      dpb_q   <= dpb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    start_d = 1'b0;
    sel_d   = sel_q;
    dpa_d   = dpa_q;
    dpb_d   = dpb_q;
    res_d   = res_q;
    // The pointer only breaks ties; a lone requester wins outright.
    win     = (req0 && req1) ? ptr_q : req1;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          ptr_d   = ~win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          start_d = 1'b1;
          sel_d   = win ? op1 : op0;
          dpa_d   = win ? a1 : a0;
          dpb_d   = win ? b1 : b0;
          cnt_d   = (win ? op1 : op0) ? DIV_CNT : ADD_CNT;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 8'd1;
        // Capture on the edge that takes the counter to zero. The done flag
        // is registered here, so it is high for exactly the DONE cycle.
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          res_d   = sel_q ? div_res : sum_res;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign busy     = (state_q != IDLE);
  assign dp_a     = dpa_q;
  assign dp_b     = dpb_q;
  assign dp_sel   = sel_q;
  assign dp_start = start_q;

endmodule

// File: tb/tb_fpu_sched.sv
module tb_fpu_sched;

  localparam int unsigned DIV_LAT = 24;
  localparam int unsigned ADD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, busy, dp_sel, dp_start;
  logic [31:0] res, dp_a, dp_b, sum_res, div_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_sched #(.DIV_LAT(DIV_LAT), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_start(dp_start),
    .sum_res(sum_res), .div_res(div_res)
  );

  // Stand-in shared units: exact IEEE results for the directed operand pair,
  // a distinct deterministic pattern otherwise.
  function automatic logic [31:0] unit_fn(input logic sel, input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40E00000 && b == 32'h40A00000)
      return sel ? 32'h3FB33333 : 32'h41400000;
    return sel ? (a ^ {b[15:0], b[31:16]}) : (a + b);
  endfunction

  assign sum_res = unit_fn(1'b0, dp_a, dp_b);
  assign div_res = unit_fn(1'b1, dp_a, dp_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction model: one job remembered by its issue edge index and latency.
  int          n = 0;
  logic        m_active = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, m_sel = 1'b0;
  int          m_issue = 0, m_lat = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_win;

  assign m_win = (req0 && req1) ? m_ptr : req1;

  always @(posedge clk) n <= n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_owner  <= 1'b0;
      m_ptr    <= 1'b0;
      m_sel    <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      m_res    <= '0;
    end else begin
      if (m_active && (n + 1 == m_issue + m_lat))
        m_res <= unit_fn(m_sel, m_a, m_b);
      if ((!m_active || (n + 1 > m_issue + m_lat + 1)) && (req0 || req1)) begin
        m_active <= 1'b1;
        m_issue  <= n + 1;
        m_owner  <= m_win;
        m_ptr    <= ~m_win;
        m_sel    <= m_win ? op1 : op0;
        m_a      <= m_win ? a1 : a0;
        m_b      <= m_win ? b1 : b0;
        m_lat    <= (m_win ? op1 : op0) ? int'(DIV_LAT) : int'(ADD_LAT);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt0",     gnt0,     m_active && n == m_issue && !m_owner);
      chk("gnt1",     gnt1,     m_active && n == m_issue && m_owner);
      chk("dp_start", dp_start, m_active && n == m_issue);
      chk("done0",    done0,    m_active && n == m_issue + m_lat && !m_owner);
      chk("done1",    done1,    m_active && n == m_issue + m_lat && m_owner);
      chk("busy",     busy,     m_active && n >= m_issue && n <= m_issue + m_lat);
      chk("dp_a",     dp_a,     m_a);
      chk("dp_b",     dp_b,     m_b);
      chk("dp_sel",   dp_sel,   m_sel);
      chk("res",      res,      m_res);
      chk("excl",     (gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1)), 32'd0);
    end
  end

  function automatic logic pick(input int which);
    case (which)
      0: return gnt0;
      1: return gnt1;
      2: return done0;
      default: return done1;
    endcase
  endfunction

  // Counts falling edges until the chosen pulse is seen; -1 on timeout.
  task automatic wait_sig(input int which, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (pick(which)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic who, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_res, input string tag);
    int c;
    @(negedge clk);
    if (who) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    wait_sig(who ? 1 : 0, 10, c);
    chk({tag, "_gnt_cyc"}, c, 1);
    wait_sig(who ? 3 : 2, 300, c);
    chk({tag, "_done_cyc"}, c, lat);
    if (who) req1 = 1'b0; else req0 = 1'b0;
    chk({tag, "_res"}, res, exp_res);
  endtask

  initial begin
    int c, k;
    int order [3];

    repeat (2) @(negedge clk);
    chk("rst_ctl", {gnt0, gnt1, done0, done1, busy, dp_start, dp_sel}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_dpa", dp_a | dp_b, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Divide on requester 0, add on requester 1.
    run_op(1'b0, 1'b1, 32'h40E00000, 32'h40A00000, 24, 32'h3FB33333, "div0");
    run_op(1'b1, 1'b0, 32'h40E00000, 32'h40A00000, 1, 32'h41400000, "add1");
    @(negedge clk);
    chk("add1_busy_low", busy, 1'b0);
    repeat (2) @(negedge clk);

    // Both requesting and held: round-robin 0,1,0; req1 waits during 0's run.
    req0 = 1'b1; op0 = 1'b0; a0 = 32'h40E00000; b0 = 32'h40A00000;
    req1 = 1'b1; op1 = 1'b1; a1 = 32'h3F800000; b1 = 32'h40000000;
    k = 0;
    for (int i = 0; i < 300 && k < 3; i++) begin
      @(negedge clk);
      if (gnt0) begin order[k] = 0; k++; end
      else if (gnt1) begin order[k] = 1; k++; end
    end
    req1 = 1'b0;
    chk("rr_count", k, 3);
    chk("rr_first", order[0], 0);
    chk("rr_second", order[1], 1);
    chk("rr_third", order[2], 0);
    wait_sig(2, 50, c);
    chk("rr_done0", c, 1);
    req0 = 1'b0;
    chk("rr_res", res, 32'h41400000);
    repeat (2) @(negedge clk);

    // Request withdrawn and operand clobbered right after the grant.
    req0 = 1'b1; op0 = 1'b1; a0 = 32'h40E00000; b0 = 32'h40A00000;
    wait_sig(0, 10, c);
    chk("hold_gnt", c, 1);
    req0 = 1'b0; a0 = 32'h00000000;
    wait_sig(2, 100, c);
    chk("hold_done_cyc", c, 24);
    chk("hold_res", res, 32'h3FB33333);
    repeat (2) @(negedge clk);

    // Reset mid-run: outputs clear immediately, job is dropped.
    req1 = 1'b1; op1 = 1'b0; a1 = 32'h40E00000; b1 = 32'h40A00000;
    wait_sig(1, 10, c);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    req0 = 1'b1; op0 = 1'b1;
    wait_sig(0, 10, c);
    chk("abort_gnt", c, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ctl", {gnt0, gnt1, done0, done1, busy, dp_start, dp_sel}, 32'd0);
    chk("async_res", res, 32'd0);
    chk("async_dp", dp_a | dp_b, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Pointer is back at 0, so requester 0 wins the tie, with full latency.
    req0 = 1'b1; op0 = 1'b1; a0 = 32'h40E00000; b0 = 32'h40A00000;
    req1 = 1'b1; op1 = 1'b0; a1 = 32'h40E00000; b1 = 32'h40A00000;
    wait_sig(0, 5, c);
    chk("post_rst_gnt0", c, 1);
    wait_sig(2, 100, c);
    chk("post_rst_lat", c, 24);
    req0 = 1'b0;
    chk("post_rst_res", res, 32'h3FB33333);
    wait_sig(3, 20, c);
    chk("post_rst_done1", c, 3);
    req1 = 1'b0;
    chk("post_rst_res1", res, 32'h41400000);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
